// File: rtl/edge_detector_bank.sv
// edge_detector_bank
// Per-channel synchroniser, debounce filter and configurable edge detector.
// Accepted edges raise a one-cycle pulse and a sticky pending flag; irq is
// the OR of all pending flags.

module edge_detector_bank #(
    parameter int unsigned CHANNELS        = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   raw_inputs,
    input  logic [2*CHANNELS-1:0] edge_modes,
    input  logic [CHANNELS-1:0]   clear_pending,
    output logic [CHANNELS-1:0]   stable_values,
    output logic [CHANNELS-1:0]   edges,
    output logic [CHANNELS-1:0]   pending,
    output logic                  irq
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] synced;

    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] stable_q, stable_d;
    logic [CHANNELS-1:0] edges_q, edges_d;
    logic [CHANNELS-1:0] pending_q, pending_d;

    assign synced = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: raw levels shift through SYNC_STAGES flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= raw_inputs;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Debounce counters, stable-level update, edge qualification and pending flags
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        edges_d  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (synced[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // Level persisted long enough: accept it and qualify the
                // transition direction against the mode sampled right now.
                stable_d[i] = synced[i];
                cnt_d[i]    = '0;
                edges_d[i]  = synced[i] ? edge_modes[2*i] : edge_modes[2*i+1];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        // A newly detected edge wins over a simultaneous clear
        pending_d = (pending_q & ~clear_pending) | edges_d;
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '{default: '0};
            stable_q  <= '0;
            edges_q   <= '0;
            pending_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            edges_q   <= edges_d;
            pending_q <= pending_d;
        end
    end

    assign stable_values = stable_q;
    assign edges         = edges_q;
    assign pending       = pending_q;
    assign irq           = |pending_q;

endmodule

// File: tb/tb_edge_detector_bank.sv
// tb_edge_detector_bank
// Directed scenarios plus randomized traffic, checked every cycle against a
// window-based reference model of the debounce/edge behaviour.

module tb_edge_detector_bank;

    localparam int CH = 8;
    localparam int S  = 2;
    localparam int DC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     raw;
    logic [2*CH-1:0]   modes;
    logic [CH-1:0]     clr;
    logic [CH-1:0]     stable_values;
    logic [CH-1:0]     edges;
    logic [CH-1:0]     pending;
    logic              irq;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    bit [CH-1:0] rawh[$];   // raw values seen at past edges, newest first
    bit [CH-1:0] synh[$];   // synced values seen at the last DC edges
    bit [CH-1:0] m_stable, m_edges, m_pend;

    edge_detector_bank #(
        .CHANNELS(CH),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .raw_inputs(raw),
        .edge_modes(modes),
        .clear_pending(clr),
        .stable_values(stable_values),
        .edges(edges),
        .pending(pending),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        rawh.delete();
        synh.delete();
        repeat (S)  rawh.push_front('0);
        repeat (DC) synh.push_front('0);
        m_stable = '0;
        m_edges  = '0;
        m_pend   = '0;
    endtask

    // A level is accepted once the last DC synced samples all disagree with
    // the current stable level; synced is the raw value from S edges earlier.
    task automatic model_update();
        bit [CH-1:0] synced_v;
        bit all_diff;
        if (!rst) begin
            model_reset();
            return;
        end
        synced_v = rawh[S-1];
        rawh.push_front(raw);
        void'(rawh.pop_back());
        synh.push_front(synced_v);
        void'(synh.pop_back());
        m_edges = '0;
        for (int i = 0; i < CH; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++) begin
                if (synh[j][i] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_stable[i] = ~m_stable[i];
                m_edges[i]  = m_stable[i] ? modes[2*i] : modes[2*i+1];
            end
        end
        m_pend = (m_pend & ~clr) | m_edges;
    endtask

    task automatic check_model();
        chk("stable",  32'(stable_values), 32'(m_stable));
        chk("edges",   32'(edges),         32'(m_edges));
        chk("pending", 32'(pending),       32'(m_pend));
        chk("irq",     32'(irq),           32'(|m_pend));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    // Assert reset between edges, check outputs cleared without a clock,
    // hold through one edge, release.
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk({tag, "_stable"},  32'(stable_values), 32'd0);
        chk({tag, "_edges"},   32'(edges),         32'd0);
        chk({tag, "_pending"}, 32'(pending),       32'd0);
        chk({tag, "_irq"},     32'(irq),           32'd0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [CH-1:0] flip;
        rst   = 1'b0;
        raw   = '0;
        modes = '0;
        clr   = '0;
        model_reset();
        #1;
        chk("reset_stable",  32'(stable_values), 32'd0);
        chk("reset_pending", 32'(pending),       32'd0);
        chk("reset_irq",     32'(irq),           32'd0);
        tick();
        tick();

        // Basic rising edge on ch0 with latency S+DC
        rst         = 1'b1;
        modes[1:0]  = 2'b01;
        raw[0]      = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk("lat_edge0", 32'(edges[0]), 32'(n == S + DC));
            if (n >= S + DC) begin
                chk("lat_stable0",  32'(stable_values[0]), 32'd1);
                chk("lat_pending0", 32'(pending[0]),       32'd1);
                chk("lat_irq",      32'(irq),              32'd1);
            end
        end

        // 3-cycle glitch on ch1 is rejected
        modes[3:2] = 2'b11;
        raw[1]     = 1'b1;
        repeat (3) tick();
        raw[1] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("glitch_edge1",   32'(edges[1]),         32'd0);
            chk("glitch_stable1", 32'(stable_values[1]), 32'd0);
        end

        // Clear held while ch0 detects a falling edge: set wins, then clears
        modes[1:0] = 2'b11;
        clr        = '1;
        raw[0]     = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (n == S + DC) begin
                chk("setwin_edge0",    32'(edges[0]),   32'd1);
                chk("setwin_pending0", 32'(pending[0]), 32'd1);
            end
            if (n == S + DC + 1) begin
                chk("clear_pending0", 32'(pending[0]), 32'd0);
                chk("clear_irq",      32'(irq),        32'd0);
            end
        end
        clr = '0;

        // ch2 falling-only, ch3 off
        modes[5:4] = 2'b10;
        modes[7:6] = 2'b00;
        raw[3:2]   = 2'b11;
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk("rise_sup_edge2", 32'(edges[2]),   32'd0);
            chk("off_edge3",      32'(edges[3]),   32'd0);
            chk("off_pending3",   32'(pending[3]), 32'd0);
        end
        chk("mode_stable_hi", 32'(stable_values[3:2]), 32'd3);
        raw[3:2] = 2'b00;
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk("fall_edge2",   32'(edges[2]),   32'(n == S + DC));
            chk("off_edge3",    32'(edges[3]),   32'd0);
            chk("off_pending3", 32'(pending[3]), 32'd0);
        end
        chk("mode_stable_lo", 32'(stable_values[3:2]), 32'd0);
        chk("fall_pending2",  32'(pending[2]),         32'd1);

        // All channels toggle together in mode 11
        clr = '1;
        tick();
        clr   = '0;
        modes = '1;
        raw   = ~m_stable;
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk("all_edges", 32'(edges), (n == S + DC) ? 32'hFF : 32'h00);
            if (n >= S + DC) chk("all_pending", 32'(pending), 32'hFF);
        end

        // Reset in the middle of a ch4 debounce
        raw = '0;
        repeat (8) tick();
        clr = '1;
        tick();
        clr    = '0;
        raw[4] = 1'b1;
        repeat (3) tick();
        async_reset("midrst");
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk("midrst_edge4", 32'(edges[4]), 32'(n == S + DC));
        end

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            flip = '0;
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(7) == 0) flip[i] = 1'b1;
            end
            raw = raw ^ flip;
            if ($urandom_range(31) == 0) modes = 16'($urandom);
            clr = CH'($urandom & $urandom & $urandom);
            if (k % 200 == 100) async_reset("rnd_rst");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
